// File: rtl/shapool_seq_if.sv
// Round handshake between the sequencer and the hashing pool.
interface shapool_seq_if #(
  parameter int unsigned POOL_SIZE = 2,
  parameter int unsigned BASE_W    = 31
);
  logic                 core_start;
  logic [BASE_W-1:0]    core_nonce;
  logic                 core_done;
  logic [POOL_SIZE-1:0] core_match;

  modport master (output core_start, core_nonce, input core_done, core_match);
  modport slave  (input core_start, core_nonce, output core_done, core_match);
endinterface

// File: rtl/shapool_sequencer.sv
// Round-level controller for the SHA-256d pool: issues rounds and base nonces,
// evaluates match flags, and drives done chain, success line and LEDs.
module shapool_sequencer #(
  parameter int unsigned POOL_SIZE       = 2,
  parameter int unsigned POOL_SIZE_LOG2  = 1,
  parameter int unsigned NONCE_WIDTH     = 32,
  parameter int unsigned WATCHDOG_CYCLES = 256,
  parameter int unsigned BLINK_LOG2      = 22
) (
  input  logic                                  hwclk,
  input  logic                                  reset_in,
  input  logic                                  job_loaded,
  shapool_seq_if.master                         pool,
  input  logic                                  success_in,
  output logic                                  success_drive,
  output logic [POOL_SIZE_LOG2-1:0]             winner_idx,
  output logic [NONCE_WIDTH-POOL_SIZE_LOG2-1:0] winner_nonce,
  input  logic                                  done_in,
  output logic                                  done_out,
  output logic                                  busy,
  output logic                                  status_led,
  output logic                                  success_led
);
  localparam int unsigned BASE_W = NONCE_WIDTH - POOL_SIZE_LOG2;
  localparam int unsigned WD_W   = $clog2(WATCHDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [BLINK_LOG2-1:0] SLOW_MASK = '1;
  localparam logic [BLINK_LOG2-1:0] FAST_MASK = BLINK_LOG2'((64'd1 << (BLINK_LOG2 - 2)) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_EVAL, S_FOUND, S_HALT, S_EXHAUSTED, S_FAULT
  } state_t;

  state_t                    state, state_d;
  logic [WD_W-1:0]           wd;
  logic [POOL_SIZE-1:0]      match_q;
  logic [BLINK_LOG2-1:0]     div;
  logic                      local_done;
  logic [POOL_SIZE_LOG2-1:0] low_idx_c;
  logic                      run_d_c;
  logic                      term_d_c;

  // Lowest-numbered core among the registered match flags
  always_comb begin
    low_idx_c = '0;
    for (int i = int'(POOL_SIZE) - 1; i >= 0; i--) begin
      if (match_q[i]) low_idx_c = POOL_SIZE_LOG2'(i);
    end
  end

  // Next-state logic; a new job overrides everything
  always_comb begin
    state_d = state;
    if (job_loaded) begin
      state_d = S_START;
    end else begin
      case (state)
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (pool.core_done)    state_d = S_EVAL;
          else if (success_in)   state_d = S_HALT;
          else if (wd >= WD_LAST) state_d = S_FAULT;
        end
        S_EVAL: begin
          if (|match_q)              state_d = S_FOUND;
          else if (&pool.core_nonce) state_d = S_EXHAUSTED;
          else                       state_d = S_START;
        end
        default: state_d = state;
      endcase
    end
  end

  assign run_d_c  = (state_d == S_START) || (state_d == S_WAIT);
  assign term_d_c = (state_d == S_FOUND) || (state_d == S_HALT) ||
                    (state_d == S_EXHAUSTED) || (state_d == S_FAULT);

  // State register and registered outputs decoded from the next state
  always_ff @(posedge hwclk or negedge reset_in) begin
    if (!reset_in) begin
      state           <= S_IDLE;
      pool.core_start <= 1'b0;
      pool.core_nonce <= '0;
      wd              <= '0;
      match_q         <= '0;
      div             <= '0;
      winner_idx      <= '0;
      winner_nonce    <= '0;
      success_drive   <= 1'b0;
      success_led     <= 1'b0;
      local_done      <= 1'b0;
      done_out        <= 1'b0;
      busy            <= 1'b0;
      status_led      <= 1'b0;
    end else begin
      state           <= state_d;
      pool.core_start <= (state_d == S_START);
      busy            <= run_d_c;
      success_drive   <= (state_d == S_FOUND);
      success_led     <= (state_d == S_FOUND);
      local_done      <= term_d_c;
      done_out        <= local_done & done_in;
      div             <= div + BLINK_LOG2'(1);

      if (job_loaded) begin
        pool.core_nonce <= '0;
      end else if (state == S_EVAL && state_d == S_START) begin
        pool.core_nonce <= pool.core_nonce + BASE_W'(1);
      end

      // Watchdog restarts with each round and saturates
      if (state_d == S_START) begin
        wd <= '0;
      end else if ((state == S_START || state == S_WAIT) && wd != WD_MAX) begin
        wd <= wd + WD_W'(1);
      end

      if (state == S_WAIT && state_d == S_EVAL) begin
        match_q <= pool.core_match;
      end

      if (job_loaded) begin
        winner_idx   <= '0;
        winner_nonce <= '0;
      end else if (state == S_EVAL && state_d == S_FOUND) begin
        winner_idx   <= low_idx_c;
        winner_nonce <= pool.core_nonce;
      end

      // Slow blink while running, fast blink on fault, steady when finished
      case (state_d)
        S_IDLE:         status_led <= 1'b0;
        S_START, S_WAIT: if (div == SLOW_MASK) status_led <= ~status_led;
        S_FAULT:        if ((div & FAST_MASK) == FAST_MASK) status_led <= ~status_led;
        S_EVAL:         status_led <= status_led;
        default:        status_led <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_shapool_sequencer.sv
// Self-checking bench for shapool_sequencer: scenario table plus directed corner cases.
module tb_shapool_sequencer;
  localparam int unsigned NW = 4;
  localparam int unsigned PS = 2;
  localparam int unsigned PL = 1;
  localparam int unsigned WD = 16;
  localparam int unsigned BL = 3;
  localparam int unsigned BW = NW - PL;

  logic          hwclk = 1'b0;
  logic          reset_in = 1'b0;
  logic          job_loaded = 1'b0;
  logic          success_in = 1'b0;
  logic          done_in = 1'b1;
  logic          success_drive;
  logic [PL-1:0] winner_idx;
  logic [BW-1:0] winner_nonce;
  logic          done_out;
  logic          busy;
  logic          status_led;
  logic          success_led;

  always #5 hwclk = ~hwclk;

  shapool_seq_if #(.POOL_SIZE(PS), .BASE_W(BW)) pool ();

  shapool_sequencer #(
    .POOL_SIZE(PS), .POOL_SIZE_LOG2(PL), .NONCE_WIDTH(NW),
    .WATCHDOG_CYCLES(WD), .BLINK_LOG2(BL)
  ) dut (
    .hwclk(hwclk), .reset_in(reset_in), .job_loaded(job_loaded), .pool(pool),
    .success_in(success_in), .success_drive(success_drive),
    .winner_idx(winner_idx), .winner_nonce(winner_nonce),
    .done_in(done_in), .done_out(done_out), .busy(busy),
    .status_led(status_led), .success_led(success_led)
  );

  int passes = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];

  typedef struct {
    int          hit;
    logic [1:0]  match;
    int          rounds;
    logic        drive;
    logic [PL-1:0] idx;
    logic [BW-1:0] wn;
  } scen_t;
  scen_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge hwclk);
    #1;
  endtask

  task automatic pulse_job();
    job_loaded = 1'b1;
    step();
    job_loaded = 1'b0;
  endtask

  // Waits (bounded) for core_start and compares its nonce with the scoreboard
  task automatic wait_start();
    int n = 0;
    logic [BW-1:0] e;
    while (!pool.core_start && n < 8) begin
      step();
      n++;
    end
    check("core_start_seen", 32'(pool.core_start), 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("core_nonce", 32'(pool.core_nonce), 32'(e));
    end
  endtask

  task automatic do_round(input logic [1:0] match);
    wait_start();
    repeat (4) step();
    pool.core_done = 1'b1;
    pool.core_match = match;
    step();
    pool.core_done = 1'b0;
    pool.core_match = '0;
  endtask

  task automatic no_starts(input string name);
    int n = 0;
    repeat (6) begin
      if (pool.core_start) n++;
      step();
    end
    check(name, 32'(n), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic led_s[8];
    pool.core_done = 1'b0;
    pool.core_match = '0;

    tbl[0] = '{hit: 3,  match: 2'b11, rounds: 4, drive: 1'b1, idx: 1'b0, wn: 3'd3};
    tbl[1] = '{hit: 0,  match: 2'b10, rounds: 1, drive: 1'b1, idx: 1'b1, wn: 3'd0};
    tbl[2] = '{hit: -1, match: 2'b00, rounds: 8, drive: 1'b0, idx: 1'b0, wn: 3'd0};
    tbl[3] = '{hit: 7,  match: 2'b01, rounds: 8, drive: 1'b1, idx: 1'b0, wn: 3'd7};
    tbl[4] = '{hit: 5,  match: 2'b10, rounds: 6, drive: 1'b1, idx: 1'b1, wn: 3'd5};

    // Reset state
    repeat (3) step();
    check("rst_core_start", 32'(pool.core_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_out", 32'(done_out), 32'd0);
    check("rst_status_led", 32'(status_led), 32'd0);
    reset_in = 1'b1;
    step();
    check("idle_no_start", 32'(pool.core_start), 32'd0);

    // Scenario table: each starts with a fresh job, possibly from a terminal state
    for (int s = 0; s < 5; s++) begin
      for (int r = 0; r < tbl[s].rounds; r++) exp_q.push_back(BW'(r));
      pulse_job();
      check("restart_idx", 32'(winner_idx), 32'd0);
      check("restart_wnonce", 32'(winner_nonce), 32'd0);
      check("restart_drive", 32'(success_drive), 32'd0);
      for (int r = 0; r < tbl[s].rounds; r++)
        do_round((r == tbl[s].hit) ? tbl[s].match : 2'b00);
      step();
      check("end_busy", 32'(busy), 32'd0);
      check("end_drive", 32'(success_drive), 32'(tbl[s].drive));
      check("end_success_led", 32'(success_led), 32'(tbl[s].drive));
      check("end_winner_idx", 32'(winner_idx), 32'(tbl[s].idx));
      check("end_winner_nonce", 32'(winner_nonce), 32'(tbl[s].wn));
      check("end_status_led", 32'(status_led), 32'd1);
      check("end_done_lag", 32'(done_out), 32'd0);
      step();
      check("end_done_out", 32'(done_out), 32'd1);
      no_starts("end_no_more_starts");
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    end

    // External win during WAIT of the nonce-2 round
    for (int r = 0; r < 3; r++) exp_q.push_back(BW'(r));
    pulse_job();
    do_round(2'b00);
    do_round(2'b00);
    wait_start();
    step();
    step();
    success_in = 1'b1;
    step();
    success_in = 1'b0;
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_drive", 32'(success_drive), 32'd0);
    check("halt_status_led", 32'(status_led), 32'd1);
    step();
    check("halt_done_out", 32'(done_out), 32'd1);
    no_starts("halt_no_starts");

    // core_done and success_in together: local evaluation wins
    exp_q.push_back(BW'(0));
    pulse_job();
    wait_start();
    repeat (3) step();
    pool.core_done = 1'b1;
    pool.core_match = 2'b10;
    success_in = 1'b1;
    step();
    pool.core_done = 1'b0;
    pool.core_match = '0;
    success_in = 1'b0;
    step();
    check("tie_drive", 32'(success_drive), 32'd1);
    check("tie_winner_idx", 32'(winner_idx), 32'd1);
    check("tie_winner_nonce", 32'(winner_nonce), 32'd0);

    // Watchdog: no core_done after core_start
    exp_q.push_back(BW'(0));
    pulse_job();
    wait_start();
    repeat (15) step();
    check("wd_still_busy", 32'(busy), 32'd1);
    step();
    check("wd_fault_busy", 32'(busy), 32'd0);
    check("wd_fault_drive", 32'(success_drive), 32'd0);
    for (int t = 0; t < 8; t++) begin
      led_s[t] = status_led;
      step();
    end
    for (int t = 0; t < 6; t++)
      check("fault_blink", 32'(led_s[t+2] ^ led_s[t]), 32'd1);
    check("fault_done_out", 32'(done_out), 32'd1);

    // Done chain gating
    done_in = 1'b0;
    step();
    step();
    check("chain_gated", 32'(done_out), 32'd0);
    done_in = 1'b1;
    check("chain_lag", 32'(done_out), 32'd0);
    step();
    check("chain_rise", 32'(done_out), 32'd1);

    // Reset in the middle of a round
    exp_q.push_back(BW'(0));
    exp_q.push_back(BW'(1));
    pulse_job();
    do_round(2'b00);
    wait_start();
    step();
    step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset_in = 1'b0;
    #1;
    check("arst_core_nonce", 32'(pool.core_nonce), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done_out", 32'(done_out), 32'd0);
    check("arst_status_led", 32'(status_led), 32'd0);
    check("arst_drive", 32'(success_drive), 32'd0);
    step();
    reset_in = 1'b1;
    step();
    pool.core_done = 1'b1;
    pool.core_match = 2'b11;
    step();
    pool.core_done = 1'b0;
    pool.core_match = '0;
    no_starts("stray_done_no_start");
    check("stray_done_drive", 32'(success_drive), 32'd0);
    check("stray_done_doneout", 32'(done_out), 32'd0);
    check("stray_done_idx", 32'(winner_idx), 32'd0);

    // Normal operation resumes after reset
    exp_q.push_back(BW'(0));
    pulse_job();
    do_round(2'b01);
    step();
    check("post_reset_win", 32'(success_drive), 32'd1);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/shapool_sequencer.md
Name: shapool_sequencer

Overview:
- Round-level controller for the SHA-256d hashing pool inside the shapool top level.
- After a job is shifted in, it issues successive pool rounds and a base nonce for each round. Each core appends its own index to that base.
- It evaluates per-core match flags at the end of each round and latches the winning core and nonce.
- It drives the daisy-chained done flag, the shared open-drain success line and both indicator LEDs.

Parameters:
- POOL_SIZE, 2, number of hashing cores in the pool.
- POOL_SIZE_LOG2, 1, log2(POOL_SIZE); width of the core index.
- NONCE_WIDTH, 32, full nonce width; the base nonce is NONCE_WIDTH-POOL_SIZE_LOG2 bits.
- WATCHDOG_CYCLES, 256, maximum cycles from core_start to core_done before a fault is declared.
- BLINK_LOG2, 22, status LED half-period is 2^BLINK_LOG2 cycles while running.

Ports:
- hwclk  in  1  system clock; all logic is on its rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- job_loaded  in  1  one-cycle pulse, already synchronised to hwclk: a new job is fully loaded.
- core_start  out  1  one-cycle pulse that starts one pool round.
- core_nonce  out  NONCE_WIDTH-POOL_SIZE_LOG2  base nonce for the current round; stable from core_start until core_done.
- core_done  in  1  one-cycle pulse: all cores have finished the round.
- core_match  in  POOL_SIZE  per-core match flags; sampled only in the cycle core_done is high.
- success_in  in  1  synchronised, active-high view of the shared success line.
- success_drive  out  1  output enable for the open-drain success line; 1 pulls the line active.
- winner_idx  out  POOL_SIZE_LOG2  index of the lowest-numbered matching core.
- winner_nonce  out  NONCE_WIDTH-POOL_SIZE_LOG2  base nonce of the winning round.
- done_in  in  1  done flag from the upstream device; tied 1 on the first device in the chain.
- done_out  out  1  done flag to the downstream device.
- busy  out  1  high in START and WAIT.
- status_led  out  1  activity indicator.
- success_led  out  1  local-win indicator.

Behaviour:
- Reset values (reset_in=0):
  - State is IDLE.
  - All outputs are 0, including core_nonce, winner_idx and winner_nonce.
  - Nonce and watchdog counters are 0.
- States and transitions:
  - IDLE: waits for job_loaded, then goes to START with nonce=0.
  - START: core_start=1 for exactly one cycle; watchdog cleared; next state WAIT.
  - WAIT:
    - On core_done, go to EVAL and register core_match.
    - Else, if success_in=1, go to HALT.
    - Else, if the watchdog reaches WATCHDOG_CYCLES-1, go to FAULT.
  - EVAL:
    - If any registered match bit is set, go to FOUND. Latch winner_idx as the lowest set bit and winner_nonce as core_nonce.
    - Else, if core_nonce is all ones, go to EXHAUSTED.
    - Else, increment core_nonce and go to START.
  - FOUND: success_drive=1, success_led=1, local_done=1.
  - HALT, EXHAUSTED, FAULT: local_done=1, success_drive=0.
  - FOUND, HALT, EXHAUSTED and FAULT are left only by job_loaded or by reset.
- Round latency: START, then WAIT for N cycles, then EVAL. The next core_start follows 2 cycles after a non-matching core_done.
- done_out = local_done AND done_in. The output is registered, so it lags a change on done_in by 1 cycle.
- Simultaneous events:
  - job_loaded has the highest priority in every state. It clears the winner outputs, success_drive, success_led and local_done, sets nonce=0 and enters START next cycle.
  - core_done together with success_in in WAIT: core_done wins and the matches are evaluated. A local hit still drives success.
  - core_done together with watchdog expiry: core_done wins.
  - core_done in any state other than WAIT is ignored.
- Arithmetic:
  - The nonce increments modulo 2^(NONCE_WIDTH-POOL_SIZE_LOG2). Wrap never occurs, because the all-ones value leads to EXHAUSTED.
  - The watchdog counter saturates; its width is ceil(log2(WATCHDOG_CYCLES))+1.
- status_led:
  - 0 in IDLE.
  - Toggles every 2^BLINK_LOG2 cycles in START and WAIT, with the divider free-running.
  - Steady 1 in FOUND, HALT and EXHAUSTED.
  - Toggles every 2^(BLINK_LOG2-2) cycles in FAULT.
- Reset asserted mid-round: immediate return to the reset values. Cores must be ignored until the next core_start.

Test Plan:
- Bench parameters: NONCE_WIDTH=4, POOL_SIZE=2, POOL_SIZE_LOG2=1, WATCHDOG_CYCLES=16, BLINK_LOG2=3.
- Exhaustion:
  - Stimulus: job_loaded; answer every core_start with core_done after 5 cycles, core_match=00.
  - Required: 8 core_start pulses with core_nonce 0..7, then EXHAUSTED. done_out=1 one cycle after entry with done_in=1; success_drive=0.
- Local win:
  - Stimulus: core_match=11 on the round with core_nonce=3.
  - Required: winner_idx=0, winner_nonce=3, success_drive=1, success_led=1, no further core_start pulses.
- External win:
  - Stimulus: success_in=1 during WAIT of round 2 with no core_done.
  - Required: HALT, success_drive=0, done_out=1.
  - Stimulus (repeat): core_done with core_match=10 in the same cycle as success_in.
  - Required: FOUND with winner_idx=1.
- Watchdog:
  - Stimulus: withhold core_done after core_start.
  - Required: FAULT 16 cycles after core_start; status_led toggles every 2 cycles.
- Restart and chain:
  - Stimulus: job_loaded while in FOUND.
  - Required: winner outputs clear; core_start with core_nonce=0 next cycle.
  - Stimulus: done_in=0 while locally done.
  - Required: done_out stays 0, and rises 1 cycle after done_in rises.
- Reset:
  - Stimulus: reset_in=0 during WAIT.
  - Required: all outputs 0 asynchronously; IDLE after release; a stray core_done is ignored.
